fifo_wr_arb: RTL

//  Round-robin write-port arbiter for the async FIFO (fifo2) write side, in the wclk domain.

---
 rtl/fifo_wr_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter feeding the fifo2 write side (wclk domain).
// Grants one requester for up to BURST words, then rotates; never writes while wfull.
module fifo_wr_arb #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic                    grant_vld,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(BURST + 1);

    typedef enum logic {ST_IDLE, ST_BURST} st_t;

    st_t            st_q, st_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           grant_vld_q, grant_vld_d;

    logic [IDW-1:0] winner;
    logic [IDW-1:0] sel;
    logic           any_valid;

    function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
        return (p == IDW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the highest offset down so the first valid after rr_ptr wins last.
    always_comb begin
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[IDW'(idx)]) begin
                winner    = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        st_d       = st_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        sel        = owner_q;
        winc       = 1'b0;
        req_ready  = '0;

        case (st_q)
            ST_IDLE: begin
                sel = winner;
                if (any_valid && !wfull) begin
                    winc              = 1'b1;
                    req_ready[winner] = 1'b1;
                    owner_d           = winner;
                    grant_id_d        = winner;
                    if (BURST == 1) begin
                        rr_ptr_d = ptr_inc(winner);
                    end else begin
                        st_d  = ST_BURST;
                        cnt_d = CW'(1);
                    end
                end
            end
            ST_BURST: begin
                req_ready[owner_q] = !wfull;
                winc               = req_valid[owner_q] && !wfull;
                if (!req_valid[owner_q]) begin
                    st_d     = ST_IDLE;
                    rr_ptr_d = ptr_inc(owner_q);
                end else if (!wfull) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(BURST)) begin
                        st_d     = ST_IDLE;
                        rr_ptr_d = ptr_inc(owner_q);
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase

        // A word presented while reset is low must never reach the FIFO.
        if (!wrst_n) begin
            winc      = 1'b0;
            req_ready = '0;
        end

        grant_vld_d = (st_d == ST_BURST);
        wdata       = winc ? req_data[int'(sel)*DSIZE +: DSIZE] : '0;
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            st_q        <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            st_q        <= st_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            grant_vld_q <= grant_vld_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign grant_vld = grant_vld_q;
    assign grant_id  = grant_id_q;

    a_no_winc_full: assert property (@(posedge wclk) disable iff (!wrst_n) !(winc && wfull));
    a_ready_onehot: assert property (@(posedge wclk) disable iff (!wrst_n) $onehot0(req_ready));
    a_cnt_bound:    assert property (@(posedge wclk) disable iff (!wrst_n) cnt_q <= CW'(BURST));

endmodule
